// File: rtl/skid_buffer16_pkg.sv
// Shared definitions for the two-entry valid/ready skid buffer.
//   state_e       : control FSM encoding (EMPTY / ONE / FULL)
//   DEFAULT_WIDTH : default data word width
//   OCC_W         : width of the occupancy count
package skid_buffer16_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned OCC_W         = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

endpackage : skid_buffer16_pkg

// File: rtl/skid_buffer16_dreg_en_arst.sv
// WIDTH-bit data register with load enable and asynchronous active-low reset.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low, loads RST_VAL
//   en_i  : load enable
//   d_i   : next value
//   q_o   : registered value
module dreg_en_arst #(
  parameter int unsigned             WIDTH   = 16,
  parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule : dreg_en_arst

// File: rtl/skid_buffer16.sv
// Two-entry valid/ready skid buffer feeding the 16-bit data register stage.
// in_ready is decoded from registered state only, so the consumer's ready
// never reaches the producer combinationally; one extra word is absorbed in
// the skid register while the consumer stalls.
// Ports:
//   clk, reset          : rising-edge clock, async active-low reset
//   flush               : synchronous discard of all held words
//   in_valid/in_data    : producer side, in_ready back to producer
//   out_valid/out_data  : consumer side, out_ready from consumer
//   occupancy           : words currently held (0..2)
module skid_buffer16
  import skid_buffer16_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  state_e           state_q;
  state_e           state_d;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs decoded purely from state. An illegal encoding
  // advertises nothing so no word is accepted and then lost on recovery.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    occupancy = OCC_W'(0);
    case (state_q)
      ST_EMPTY: begin
        in_ready  = 1'b1;
      end
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = OCC_W'(1);
      end
      ST_FULL: begin
        out_valid = 1'b1;
        occupancy = OCC_W'(2);
      end
      default: ;
    endcase
  end

  // Next state and data-register load controls; flush overrides everything
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    skid_d  = in_data;
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b1;
      skid_en = 1'b1;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_en = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_en = 1'b1;
          end else if (in_xfer) begin
            skid_en = 1'b1;
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is 0 here, so only the consumer side can move
          if (out_xfer) begin
            main_en = 1'b1;
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Main register drives out_data directly and holds after draining
  dreg_en_arst #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (out_data)
  );

  // Skid register holds the overflow word while the consumer stalls
  dreg_en_arst #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (skid_en),
    .d_i   (skid_d),
    .q_o   (skid_q)
  );

endmodule : skid_buffer16

// File: tb/tb_skid_buffer16.sv
// Directed and random checks for skid_buffer16 with hand-computed expectations.
module tb_skid_buffer16;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [1:0]  occupancy;

  int checks;
  int failures;

  skid_buffer16 #(.WIDTH(16), .RST_VAL(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample/drive 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] occ, input logic rdy,
                           input logic vld, input logic [15:0] dat);
    chk({tag, "_occ"}, 16'(occupancy), 16'(occ));
    chk({tag, "_rdy"}, 16'(in_ready), 16'(rdy));
    chk({tag, "_vld"}, 16'(out_valid), 16'(vld));
    chk({tag, "_dat"}, out_data, dat);
  endtask

  logic [15:0] sb[$];
  logic [15:0] exp_w;
  logic        acc_in;
  logic        acc_out;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    out_ready = 1'b0;

    // Reset held low for 3 cycles
    repeat (3) tick();
    chk_state("rst_hold", 2'd0, 1'b1, 1'b0, 16'h0000);
    reset = 1'b1;

    // First word after reset, visible one cycle after acceptance
    in_valid = 1'b1;
    in_data  = 16'hA5A5;
    tick();
    chk_state("first_word", 2'd1, 1'b1, 1'b1, 16'hA5A5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    // Drained: out_data holds its last value
    chk_state("drain_hold", 2'd0, 1'b1, 1'b0, 16'hA5A5);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      tick();
      chk("stream_dat", out_data, 16'(i));
      chk("stream_occ", 16'(occupancy), 16'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_occ", 16'(occupancy), 16'd0);

    // Back-pressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    tick();
    chk_state("bp_one", 2'd1, 1'b1, 1'b1, 16'h1111);
    in_data = 16'h2222;
    tick();
    chk_state("bp_full", 2'd2, 1'b0, 1'b1, 16'h1111);
    in_data = 16'h3333;
    tick();
    chk_state("bp_reject", 2'd2, 1'b0, 1'b1, 16'h1111);
    out_ready = 1'b1;
    tick();
    // 1111 left at this edge; 3333 still waiting because in_ready was 0
    chk_state("bp_rel1", 2'd1, 1'b1, 1'b1, 16'h2222);
    tick();
    chk_state("bp_rel2", 2'd1, 1'b1, 1'b1, 16'h3333);
    in_valid = 1'b0;
    tick();
    chk_state("bp_drain", 2'd0, 1'b1, 1'b0, 16'h3333);

    // Flush from FULL while a word is offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h4444;
    tick();
    in_data = 16'h5555;
    tick();
    chk("fl_pre_occ", 16'(occupancy), 16'd2);
    flush   = 1'b1;
    in_data = 16'hBEEF;
    tick();
    chk_state("flush", 2'd0, 1'b1, 1'b0, 16'h0000);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_state("flush_after", 2'd0, 1'b1, 1'b0, 16'h0000);
    in_valid = 1'b1;
    in_data  = 16'h6666;
    tick();
    chk_state("flush_next", 2'd1, 1'b1, 1'b1, 16'h6666);

    // Asynchronous reset mid-cycle while FULL
    in_data = 16'h7777;
    tick();
    chk("ar_pre_occ", 16'(occupancy), 16'd2);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_state("async_rst", 2'd0, 1'b1, 1'b0, 16'h0000);
    tick();
    reset = 1'b1;
    tick();
    chk_state("ar_release", 2'd0, 1'b1, 1'b0, 16'h0000);

    // Random stress against a scoreboard queue
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      chk("rs_rdy", 16'(in_ready), 16'(sb.size() < 2));
      chk("rs_vld", 16'(out_valid), 16'(sb.size() != 0));
      acc_in  = in_valid && (sb.size() < 2);
      acc_out = out_ready && (sb.size() != 0);
      if (acc_out) begin
        exp_w = sb.pop_front();
        chk("rs_dat", out_data, exp_w);
      end
      if (acc_in) sb.push_back(in_data);
      tick();
      chk("rs_occ", 16'(occupancy), 16'(sb.size()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_skid_buffer16

// File: doc/skid_buffer16.md
Name: skid_buffer16

Overview:
- Two-entry valid/ready skid buffer that sits directly upstream of the team's 16-bit data register stage and feeds it.
- Breaks the combinational ready path between producer and consumer.
- Sustains one word per cycle with full throughput.
- Absorbs one word of back-pressure without loss.

Parameters:
- WIDTH, 16: data word width in bits.
- RST_VAL, 0: value loaded into both data registers on reset and on flush.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted.
- flush  input  1  synchronous discard of all held data. Active-high.
- in_valid  input  1  producer presents in_data this cycle.
- in_data  input  WIDTH  producer data word.
- in_ready  output  1  buffer accepts a word this cycle. Registered output.
- out_valid  output  1  out_data holds a valid word. Registered output.
- out_data  output  WIDTH  word toward the downstream register stage. Registered output.
- out_ready  input  1  consumer takes out_data this cycle.
- occupancy  output  2  number of words held: 0, 1 or 2.

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid and in_ready are both 1 at a rising edge of clk.
  - Output transfer occurs when out_valid and out_ready are both 1 at a rising edge of clk.
- Storage: a main register drives out_data. A skid register holds the overflow word.
- State machine (2-bit state register):
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - ONE: occupancy 1, out_valid 1, in_ready 1.
  - FULL: occupancy 2, out_valid 1, in_ready 0.
- Transitions (evaluated at each rising edge, flush 0):
  - EMPTY, in xfer: main <= in_data; go to ONE.
  - EMPTY, no in xfer: stay in EMPTY.
  - ONE, in xfer and out xfer: main <= in_data; stay in ONE.
  - ONE, in xfer only: skid <= in_data; go to FULL. in_ready goes 0 in the next cycle.
  - ONE, out xfer only: go to EMPTY.
  - ONE, neither: hold.
  - FULL, out xfer: main <= skid; go to ONE.
  - FULL, no out xfer: hold. in_valid is ignored because in_ready is 0.
- Latency:
  - A word accepted in cycle N appears on out_data in cycle N+1 when the buffer was EMPTY.
  - Throughput is one word per cycle whenever out_ready stays 1.
- Ordering: strict FIFO order, with no duplication and no loss.
- out_data stability:
  - Holds its value while out_valid is 1 and out_ready is 0.
  - Holds its last value after the buffer drains to EMPTY. It is not cleared.
- Registered outputs: in_ready, out_valid and occupancy are decoded from registered state, with no combinational path from any input.
- flush:
  - Has priority over every transfer in the same cycle.
  - Next state is EMPTY and both data registers load RST_VAL.
  - A word presented in the flush cycle is dropped, even though in_ready was 1.
- reset low, at any time, including mid-transfer:
  - state goes to EMPTY immediately, without waiting for a clock edge.
  - out_valid = 0, in_ready = 1, occupancy = 0.
  - out_data = RST_VAL and skid = RST_VAL.
  - First transfers are possible at the first rising edge after reset is released.
- Width rule: data passes through unmodified, with no padding or truncation.
- Illegal state encoding: recovers to EMPTY on the next edge.

Decomposition:
- Shared package holds:
  - State encodings: ST_EMPTY = 2'b00, ST_ONE = 2'b01, ST_FULL = 2'b10.
  - Default WIDTH = 16.
- Sub-module: one WIDTH-bit async-active-low-reset data register with load enable, named dreg_en_arst. It is instantiated twice, once for main and once for skid.
- Control FSM stays inline in skid_buffer16.

Test Plan:
- Reset release: hold reset=0 for 3 cycles, then set it to 1. Required response:
  - While reset is low: out_valid=0, in_ready=1, occupancy=0, out_data=16'h0000.
  - First accepted word 16'hA5A5 appears one cycle after acceptance.
- Streaming: out_ready=1, send 16'h0001..16'h0008 on consecutive cycles. Required response:
  - out_data shows the same 8 words, in order, on consecutive cycles, each one cycle late.
  - occupancy stays at 1 throughout.
- Back-pressure: out_ready=0, send 16'h1111 then 16'h2222. Required response:
  - occupancy reaches 2 and in_ready=0.
  - 16'h3333 offered in the next cycle is not accepted.
  - Release out_ready: outputs 16'h1111, then 16'h2222, then 16'h3333.
- Flush: in FULL state, assert flush with in_valid=1 and in_data=16'hBEEF. Required response:
  - Next cycle: EMPTY, out_valid=0, out_data=16'h0000.
  - 16'hBEEF never appears on the output.
- Asynchronous reset mid-operation: drop reset between clock edges while in FULL. Required response:
  - out_valid falls to 0 and occupancy to 0 before the next rising edge.
- Random stress: 10,000 cycles of random in_valid and out_ready, checked against a scoreboard queue. Required response:
  - Zero mismatches.
  - occupancy always equals the scoreboard depth.
